msk_mux_buf: RTL and testbench



---
 rtl/msk_mux_buf.sv | 132 +++++++++++++
 tb/tb_msk_mux_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/msk_mux_buf.sv
// msk_mux_buf: registered N-way share-wise multiplexer for masked words,
// followed by a two-entry elastic buffer with valid/ready handshakes.
// Shares are only ever copied, never combined. Storage that is emptied by a
// pop, a flush or a reset is actively zeroed so that no stale share survives.
// Share layout: bit i, share j of a word sits at index i*d+j; channel k
// occupies in_data[k*W*d +: W*d].
module msk_mux_buf #(
    parameter  int d    = 2,
    parameter  int W    = 8,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N*W*d-1:0]    in_data,
    input  logic [SELW-1:0]     in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [W*d-1:0]      out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err
);

    localparam int WD = W * d;

    // Copy one channel's sharing out of the input bus. Only the public select
    // steers the choice; an unmatched select yields the all-zero sharing.
    function automatic logic [WD-1:0] pick_channel(
        input logic [N*WD-1:0] bus,
        input logic [SELW-1:0] sel
    );
        logic [WD-1:0] res;
        res = {WD{1'b0}};
        for (int k = 0; k < N; k++) begin
            res = (32'(sel) == 32'(k)) ? bus[k*WD +: WD] : res;
        end
        return res;
    endfunction

    logic [1:0]     cnt_r;
    logic [1:0]     cnt_s;
    logic [WD-1:0]  e0_r;
    logic [WD-1:0]  e0_s;
    logic [WD-1:0]  e1_r;
    logic [WD-1:0]  e1_s;
    logic           sel_err_r;
    logic           sel_err_s;
    logic           out_valid_r;
    logic           push_s;
    logic           pop_s;
    logic           sel_oob_s;
    logic [WD-1:0]  new_word_s;

    // Handshake decodes; in_ready depends only on registered state and rst_n.
    assign in_ready   = rst_n && (cnt_r < 2'd2);
    assign push_s     = in_valid && in_ready && !flush;
    assign pop_s      = out_valid_r && out_ready && !flush;
    assign sel_oob_s  = (32'(in_sel) >= 32'(N));
    assign new_word_s = pick_channel(in_data, in_sel);

    assign out_data  = e0_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

    // Next-state of the two-entry FIFO, with flush taking priority over transfers.
    always_comb begin
        cnt_s     = cnt_r;
        e0_s      = e0_r;
        e1_s      = e1_r;
        sel_err_s = sel_err_r;
        if (flush) begin
            cnt_s = 2'd0;
            e0_s  = {WD{1'b0}};
            e1_s  = {WD{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        e0_s  = new_word_s;
                        cnt_s = 2'd1;
                    end else begin
                        e1_s  = new_word_s;
                        cnt_s = 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_r == 2'd2) begin
                        e0_s  = e1_r;
                        e1_s  = {WD{1'b0}};
                        cnt_s = 2'd1;
                    end else begin
                        e0_s  = {WD{1'b0}};
                        cnt_s = 2'd0;
                    end
                end
                2'b11: begin
                    // Only reachable with one entry: the head is replaced in place.
                    e0_s  = new_word_s;
                    cnt_s = 2'd1;
                end
                default: begin
                    cnt_s = cnt_r;
                end
            endcase
            if (push_s && sel_oob_s) begin
                sel_err_s = 1'b1;
            end else begin
                sel_err_s = sel_err_r;
            end
        end
    end

    // State registers with synchronous active-low reset that clears all shares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= 2'd0;
            e0_r        <= {WD{1'b0}};
            e1_r        <= {WD{1'b0}};
            sel_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            e0_r        <= e0_s;
            e1_r        <= e1_s;
            sel_err_r   <= sel_err_s;
            out_valid_r <= (cnt_s != 2'd0);
        end
    end

endmodule

// File: tb/tb_msk_mux_buf.sv
// Directed bench for msk_mux_buf: default configuration plus two other
// parameter sets (d=3/W=4/N=5 and d=1/W=8/N=3) sharing clock and reset.
module tb_msk_mux_buf;

    logic clk;
    logic rst_n;

    // Instance A: d=2, W=8, N=4
    logic [63:0] in_data_a;
    logic [1:0]  in_sel_a;
    logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, sel_err_a;
    logic [15:0] out_data_a;

    // Instance B: d=3, W=4, N=5
    logic [59:0] in_data_b;
    logic [2:0]  in_sel_b;
    logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, sel_err_b;
    logic [11:0] out_data_b;

    // Instance C: d=1, W=8, N=3
    logic [23:0] in_data_c;
    logic [1:0]  in_sel_c;
    logic        in_valid_c, in_ready_c, flush_c, out_valid_c, out_ready_c, sel_err_c;
    logic [7:0]  out_data_c;

    logic [15:0] cha [4];
    logic [11:0] chb [5];
    logic [7:0]  chc [3];

    int n_pass;
    int n_chk;

    msk_mux_buf #(.d(2), .W(8), .N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_sel(in_sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .flush(flush_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .sel_err(sel_err_a)
    );

    msk_mux_buf #(.d(3), .W(4), .N(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_sel(in_sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .sel_err(sel_err_b)
    );

    msk_mux_buf #(.d(1), .W(8), .N(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_sel(in_sel_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .flush(flush_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .sel_err(sel_err_c)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        cha[0] = 16'hA5C3; cha[1] = 16'h3C96; cha[2] = 16'h0FF0; cha[3] = 16'h5A1E;
        chb[0] = 12'h5A3;  chb[1] = 12'hC0F;  chb[2] = 12'h3E1;  chb[3] = 12'h96B; chb[4] = 12'h7D4;
        chc[0] = 8'h81;    chc[1] = 8'h7E;    chc[2] = 8'hC3;
        in_data_a = {cha[3], cha[2], cha[1], cha[0]};
        in_data_b = {chb[4], chb[3], chb[2], chb[1], chb[0]};
        in_data_c = {chc[2], chc[1], chc[0]};
        in_sel_a = 2'd0; in_sel_b = 3'd0; in_sel_c = 2'd0;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0;
        in_valid_b = 1'b0; in_valid_c = 1'b0;

        // Reset held two cycles with a transfer offered.
        rst_n = 1'b0;
        in_valid_a = 1'b1;
        tick();
        tick();
        check_val("rst_in_ready",  64'(in_ready_a),  64'h0);
        check_val("rst_out_valid", 64'(out_valid_a), 64'h0);
        check_val("rst_out_data",  64'(out_data_a),  64'h0);
        check_val("rst_sel_err",   64'(sel_err_a),   64'h0);
        in_valid_a = 1'b0;
        rst_n = 1'b1;
        tick();
        check_val("rel_in_ready",  64'(in_ready_a),  64'h1);
        check_val("rel_out_valid", 64'(out_valid_a), 64'h0);

        // Stream: one word per cycle, sel cycling 0..3, one-cycle latency.
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel_a = 2'(i % 4);
            tick();
            check_val($sformatf("stream_a_data%0d", i), 64'(out_data_a), 64'(cha[i % 4]));
            check_val($sformatf("stream_a_valid%0d", i), 64'(out_valid_a), 64'h1);
        end
        check_val("stream_a_in_ready", 64'(in_ready_a), 64'h1);
        in_valid_a = 1'b0;
        tick();
        check_val("drain_a_valid", 64'(out_valid_a), 64'h0);
        check_val("drain_a_zero",  64'(out_data_a),  64'h0);

        // Backpressure: three offers, two accepted, head held stable.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a = 2'd2;
        tick();
        check_val("bp_first_data",  64'(out_data_a), 64'(cha[2]));
        check_val("bp_first_ready", 64'(in_ready_a), 64'h1);
        in_sel_a = 2'd1;
        tick();
        check_val("bp_full_ready", 64'(in_ready_a), 64'h0);
        check_val("bp_hold_data",  64'(out_data_a), 64'(cha[2]));
        in_sel_a = 2'd3;
        tick();
        check_val("bp_stall_data",  64'(out_data_a),  64'(cha[2]));
        check_val("bp_stall_valid", 64'(out_valid_a), 64'h1);
        check_val("bp_stall_ready", 64'(in_ready_a),  64'h0);
        check_val("bp_e1",          64'(dut_a.e1_r),  64'(cha[1]));
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        tick();
        check_val("bp_pop1_data",  64'(out_data_a), 64'(cha[1]));
        check_val("bp_e1_zeroed",  64'(dut_a.e1_r), 64'h0);
        check_val("bp_pop1_ready", 64'(in_ready_a), 64'h1);
        tick();
        check_val("bp_pop2_valid", 64'(out_valid_a), 64'h0);
        check_val("bp_pop2_zero",  64'(out_data_a),  64'h0);

        // Flush collision: full buffer, flush with push and pop offered.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a = 2'd0;
        tick();
        in_sel_a = 2'd3;
        tick();
        check_val("fl_full", 64'(in_ready_a), 64'h0);
        flush_a     = 1'b1;
        out_ready_a = 1'b1;
        tick();
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        check_val("fl_cnt",   64'(dut_a.cnt_r), 64'h0);
        check_val("fl_valid", 64'(out_valid_a), 64'h0);
        check_val("fl_data",  64'(out_data_a),  64'h0);
        check_val("fl_e1",    64'(dut_a.e1_r),  64'h0);

        // Reset mid-operation discards a held entry.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a = 2'd1;
        tick();
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        tick();
        check_val("midrst_valid", 64'(out_valid_a), 64'h0);
        check_val("midrst_data",  64'(out_data_a),  64'h0);
        rst_n = 1'b1;
        tick();

        // Instance B: stream over all five channels, then out-of-range selects.
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_sel_b = 3'(i);
            tick();
            check_val($sformatf("stream_b_data%0d", i), 64'(out_data_b), 64'(chb[i]));
        end
        check_val("b_err_clear", 64'(sel_err_b), 64'h0);
        in_sel_b = 3'd6;
        tick();
        check_val("b_oob_data",  64'(out_data_b),  64'h0);
        check_val("b_oob_valid", 64'(out_valid_b), 64'h1);
        check_val("b_oob_err",   64'(sel_err_b),   64'h1);
        in_sel_b = 3'd2;
        tick();
        check_val("b_after_data", 64'(out_data_b), 64'(chb[2]));
        check_val("b_err_sticky", 64'(sel_err_b),  64'h1);
        in_valid_b = 1'b0;
        tick();
        check_val("b_drain_zero", 64'(out_data_b), 64'h0);

        // Instance C: N=3 with sel=3 out of range.
        out_ready_c = 1'b1;
        in_valid_c  = 1'b1;
        in_sel_c = 2'd2;
        tick();
        check_val("c_data2", 64'(out_data_c), 64'(chc[2]));
        in_sel_c = 2'd3;
        tick();
        check_val("c_oob_data", 64'(out_data_c), 64'h0);
        check_val("c_oob_err",  64'(sel_err_c),  64'h1);
        in_sel_c = 2'd1;
        tick();
        check_val("c_after_data", 64'(out_data_c), 64'(chc[1]));
        check_val("c_err_sticky", 64'(sel_err_c),  64'h1);
        in_valid_c = 1'b0;

        // Only reset clears the sticky select error.
        rst_n = 1'b0;
        tick();
        check_val("b_err_reset", 64'(sel_err_b), 64'h0);
        check_val("c_err_reset", 64'(sel_err_c), 64'h0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
